// File: rtl/sd_spi_cmd.sv
// SPI-mode SD command initiator: frames one command with CRC7, collects R1, optional R3/R7 tail
// and an optional 512-byte read block streamed out one byte per rxVALID strobe.
module sd_spi_cmd #(
    parameter int CLKDIV  = 4,
    parameter int NCR_MAX = 8,
    parameter int TOK_MAX = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmdIDX,
    input  logic [31:0] cmdARG,
    input  logic        rspLONG,
    input  logic        rdDATA,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [7:0]  r1,
    output logic [31:0] rspEXT,
    output logic [7:0]  rxDATA,
    output logic        rxVALID,
    input  logic        sdMISO,
    output logic        sdMOSI,
    output logic        sdSCLK,
    output logic        sdCS
);
    localparam int CW = $clog2((TOK_MAX > NCR_MAX ? TOK_MAX : NCR_MAX) + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_R1, S_EXT, S_TOK, S_DATA, S_CRC, S_FIN, S_DONE
    } state_t;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    state_t        state, state_nxt;
    logic [1:0]    err_nxt;
    logic [7:0]    div_cnt;
    logic [2:0]    bit_cnt;
    logic [47:0]   tx_sh;
    logic [6:0]    rx_sh;
    logic [CW-1:0] cnt;
    logic [8:0]    dcnt;
    logic          rsp_long, rd_data;
    logic          div_end, byte_done;
    logic [7:0]    rx_byte;

    assign div_end   = (div_cnt == 8'(CLKDIV - 1));
    assign byte_done = sdSCLK && div_end && (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sh, sdMISO};
    // The frame register shifts in ones, so every byte after the command is FF for free.
    assign sdMOSI    = tx_sh[47];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err;
        case (state)
            S_IDLE: if (start) begin
                state_nxt = S_CMD;
                err_nxt   = 2'd0;
            end
            S_CMD: if (byte_done && cnt == CW'(5)) state_nxt = S_R1;
            S_R1: if (byte_done) begin
                if (!rx_byte[7]) begin
                    if (rsp_long)                state_nxt = S_EXT;
                    else if (!rd_data)           state_nxt = S_FIN;
                    else if (rx_byte[7:1] == '0) state_nxt = S_TOK;
                    else begin
                        state_nxt = S_FIN;
                        err_nxt   = 2'd3;
                    end
                end else if (cnt == CW'(NCR_MAX - 1)) begin
                    state_nxt = S_FIN;
                    err_nxt   = 2'd1;
                end
            end
            S_EXT: if (byte_done && cnt == CW'(3)) begin
                if (!rd_data)           state_nxt = S_FIN;
                else if (r1[7:1] == '0) state_nxt = S_TOK;
                else begin
                    state_nxt = S_FIN;
                    err_nxt   = 2'd3;
                end
            end
            S_TOK: if (byte_done) begin
                if (rx_byte == 8'hFE) state_nxt = S_DATA;
                else if (rx_byte != 8'hFF) begin
                    state_nxt = S_FIN;
                    err_nxt   = 2'd3;
                end else if (cnt == CW'(TOK_MAX - 1)) begin
                    state_nxt = S_FIN;
                    err_nxt   = 2'd2;
                end
            end
            S_DATA: if (byte_done && dcnt == 9'd511) state_nxt = S_CRC;
            S_CRC:  if (byte_done && cnt == CW'(1)) state_nxt = S_FIN;
            S_FIN:  if (byte_done) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 2'd0;
            r1       <= 8'hFF;
            rspEXT   <= '0;
            rxDATA   <= '0;
            rxVALID  <= 1'b0;
            sdSCLK   <= 1'b0;
            sdCS     <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '1;
            rx_sh    <= '1;
            cnt      <= '0;
            dcnt     <= '0;
            rsp_long <= 1'b0;
            rd_data  <= 1'b0;
        end else begin
            done    <= (state == S_DONE);
            rxVALID <= 1'b0;
            err     <= err_nxt;
            // Per-state byte counter restarts on every state change.
            if (state_nxt != state) cnt <= '0;
            else if (byte_done)     cnt <= cnt + 1'b1;

            if (state == S_IDLE) begin
                div_cnt <= '0;
                bit_cnt <= '0;
                sdSCLK  <= 1'b0;
                if (start) begin
                    rsp_long <= rspLONG;
                    rd_data  <= rdDATA;
                    tx_sh    <= {2'b01, cmdIDX, cmdARG, crc7({2'b01, cmdIDX, cmdARG}), 1'b1};
                    busy     <= 1'b1;
                    sdCS     <= 1'b0;
                end
            end else if (state != S_DONE) begin
                div_cnt <= div_end ? 8'd0 : div_cnt + 8'd1;
                if (div_end) sdSCLK <= ~sdSCLK;
                // End of high phase: sample MISO and present the next MOSI bit as SCLK falls.
                if (div_end && sdSCLK) begin
                    rx_sh   <= rx_byte[6:0];
                    tx_sh   <= {tx_sh[46:0], 1'b1};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end

            if (state == S_DONE) busy <= 1'b0;
            if (state_nxt == S_FIN && state != S_FIN) sdCS <= 1'b1;

            if (byte_done) begin
                case (state)
                    S_R1:   if (!rx_byte[7]) r1 <= rx_byte;
                    S_EXT:  rspEXT <= {rspEXT[23:0], rx_byte};
                    S_DATA: begin
                        rxDATA  <= rx_byte;
                        rxVALID <= 1'b1;
                        dcnt    <= dcnt + 9'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sd_spi_cmd.sv
// Directed bench for sd_spi_cmd with a byte-stream SD card stand-in on the SPI pins.
module tb_sd_spi_cmd;
    localparam int CLKDIV = 4;
    localparam int NCR    = 8;
    localparam int TOKM   = 16;
    localparam int LIMIT  = 40000;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, rspLONG = 1'b0, rdDATA = 1'b0;
    logic        sdMISO = 1'b1;
    logic [5:0]  cmdIDX = '0;
    logic [31:0] cmdARG = '0;
    logic        busy, done, rxVALID, sdMOSI, sdSCLK, sdCS;
    logic [1:0]  err;
    logic [7:0]  r1, rxDATA;
    logic [31:0] rspEXT;

    int asserts = 0, fails = 0;

    always #5 clk = ~clk;

    sd_spi_cmd #(.CLKDIV(CLKDIV), .NCR_MAX(NCR), .TOK_MAX(TOKM)) dut (
        .clk(clk), .reset(reset), .start(start), .cmdIDX(cmdIDX), .cmdARG(cmdARG),
        .rspLONG(rspLONG), .rdDATA(rdDATA), .busy(busy), .done(done), .err(err),
        .r1(r1), .rspEXT(rspEXT), .rxDATA(rxDATA), .rxVALID(rxVALID),
        .sdMISO(sdMISO), .sdMOSI(sdMOSI), .sdSCLK(sdSCLK), .sdCS(sdCS)
    );

    // Card stand-in: replays miso_mem from CS fall (FF when exhausted), records MOSI bytes.
    logic [7:0] miso_mem[$];
    logic [7:0] mosi_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] mcur = 8'hFF, msh = 8'hFF;
    int         midx = 0, mbit = 0, mcnt = 0, done_cnt = 0;
    logic       pcs = 1'b1, psclk = 1'b0;

    always @(sdCS or sdSCLK) begin
        if (pcs === 1'b1 && sdCS === 1'b0) begin
            midx = 0; mbit = 0; mcnt = 0;
            mcur = (miso_mem.size() > 0) ? miso_mem[0] : 8'hFF;
        end else if (sdCS === 1'b0 && psclk === 1'b1 && sdSCLK === 1'b0) begin
            mbit++;
            if (mbit == 8) begin
                mbit = 0; midx++;
                mcur = (midx < miso_mem.size()) ? miso_mem[midx] : 8'hFF;
            end
        end
        if (sdCS === 1'b0 && psclk === 1'b0 && sdSCLK === 1'b1) begin
            msh = {msh[6:0], sdMOSI}; mcnt++;
            if (mcnt == 8) begin mosi_q.push_back(msh); mcnt = 0; end
        end
        pcs = sdCS; psclk = sdSCLK;
        sdMISO = (sdCS === 1'b0) ? mcur[7 - mbit] : 1'b1;
    end

    always @(negedge clk) begin
        if (rxVALID === 1'b1) rx_q.push_back(rxDATA);
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] img(input int a);
        return 8'((a * 7) ^ (a >> 5));
    endfunction

    task automatic push_ff(input int n);
        repeat (n) miso_mem.push_back(8'hFF);
    endtask

    int   cyc, mb, rb, db;
    logic cs0, busy0, mosi0;

    task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic lng,
                           input logic rd, input int poke);
        mb = mosi_q.size(); rb = rx_q.size(); db = done_cnt;
        @(negedge clk);
        cmdIDX = idx; cmdARG = arg; rspLONG = lng; rdDATA = rd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cs0 = sdCS; busy0 = busy; mosi0 = sdMOSI;
        cyc = 0;
        while (done !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (cyc == poke) begin
                cmdIDX = 6'd0; cmdARG = 32'hFFFF_FFFF; start = 1'b1;
                @(negedge clk);
                cyc++;
                start = 1'b0;
            end
        end
        asserts++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL done_timeout: no done within %0d cycles", LIMIT);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        asserts++;
        if ({sdCS, sdSCLK, sdMOSI} !== 3'b101) begin
            fails++; $display("FAIL reset_pins: got %b want 101", {sdCS, sdSCLK, sdMOSI});
        end
        asserts++;
        if ({busy, done, err, rxVALID} !== 5'b0) begin
            fails++; $display("FAIL reset_status: got %b want 00000", {busy, done, err, rxVALID});
        end
        asserts++;
        if ({r1, rspEXT, rxDATA} !== {8'hFF, 32'h0, 8'h00}) begin
            fails++; $display("FAIL reset_data: got %h want ff0000000000", {r1, rspEXT, rxDATA});
        end
    endtask

    task automatic test_cmd0;
        logic [7:0] exp_f[6];
        exp_f = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
        miso_mem.delete(); push_ff(6); miso_mem.push_back(8'h01);
        run_txn(6'd0, 32'h0, 1'b0, 1'b0, 0);
        asserts++;
        if ({cs0, busy0, mosi0} !== 3'b010) begin
            fails++; $display("FAIL cmd0_first_cycle: got %b want 010", {cs0, busy0, mosi0});
        end
        for (int i = 0; i < 6; i++) begin
            asserts++;
            if (mosi_q[mb + i] !== exp_f[i]) begin
                fails++; $display("FAIL cmd0_frame[%0d]: got %h want %h", i, mosi_q[mb + i], exp_f[i]);
            end
        end
        // 6 frame bytes + 1 poll byte under CS; the trailing byte runs with CS high.
        asserts++;
        if (mosi_q.size() - mb != 7) begin
            fails++; $display("FAIL cmd0_bytes: got %0d want 7", mosi_q.size() - mb);
        end
        // 8 bytes of 64 clocks; done shows one clock after the last SCLK fall.
        asserts++;
        if (cyc != 513) begin
            fails++; $display("FAIL cmd0_latency: got %0d want 513", cyc);
        end
        asserts++;
        if ({r1, err} !== {8'h01, 2'd0}) begin
            fails++; $display("FAIL cmd0_r1_err: got %h/%0d want 01/0", r1, err);
        end
        asserts++;
        if (done_cnt - db != 1 || sdCS !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL cmd0_end: done=%0d cs=%b busy=%b want 1/1/0", done_cnt - db, sdCS, busy);
        end
    endtask

    task automatic test_cmd8;
        miso_mem.delete(); push_ff(7);
        miso_mem.push_back(8'h01); miso_mem.push_back(8'h00); miso_mem.push_back(8'h00);
        miso_mem.push_back(8'h01); miso_mem.push_back(8'hAA);
        run_txn(6'd8, 32'h1AA, 1'b1, 1'b0, 0);
        asserts++;
        if ({mosi_q[mb], mosi_q[mb + 4], mosi_q[mb + 5]} !== 24'h48AA87) begin
            fails++; $display("FAIL cmd8_frame: got %h %h %h want 48 aa 87", mosi_q[mb], mosi_q[mb + 4], mosi_q[mb + 5]);
        end
        asserts++;
        if (rspEXT !== 32'h0000_01AA || r1 !== 8'h01 || err !== 2'd0) begin
            fails++; $display("FAIL cmd8_resp: got %h r1=%h err=%0d want 000001aa/01/0", rspEXT, r1, err);
        end
        asserts++;
        if (mosi_q.size() - mb != 12) begin
            fails++; $display("FAIL cmd8_bytes: got %0d want 12", mosi_q.size() - mb);
        end
    endtask

    task automatic load_read_stream;
        miso_mem.delete(); push_ff(8);
        miso_mem.push_back(8'h00); miso_mem.push_back(8'hFF); miso_mem.push_back(8'hFE);
        for (int a = 2560; a < 3072; a++) miso_mem.push_back(img(a));
        miso_mem.push_back(8'h12); miso_mem.push_back(8'h34);
    endtask

    task automatic test_read;
        int bad;
        load_read_stream();
        run_txn(6'd17, 32'd5, 1'b0, 1'b1, 0);
        asserts++;
        if (rx_q.size() - rb != 512) begin
            fails++; $display("FAIL read_count: got %0d want 512", rx_q.size() - rb);
        end
        bad = 0;
        for (int i = 0; i < 512 && rb + i < rx_q.size(); i++)
            if (rx_q[rb + i] !== img(2560 + i)) bad++;
        asserts++;
        if (bad != 0) begin
            fails++; $display("FAIL read_data: got %0d wrong bytes want 0", bad);
        end
        asserts++;
        if (err !== 2'd0 || r1 !== 8'h00 || rxDATA !== img(3071)) begin
            fails++; $display("FAIL read_status: err=%0d r1=%h last=%h want 0/00/%h", err, r1, rxDATA, img(3071));
        end
        asserts++;
        if (mosi_q.size() - mb != 525) begin
            fails++; $display("FAIL read_bytes: got %0d want 525", mosi_q.size() - mb);
        end
    endtask

    task automatic test_r1_timeout;
        miso_mem.delete();
        run_txn(6'd17, 32'd0, 1'b0, 1'b1, 0);
        asserts++;
        if (err !== 2'd1 || rx_q.size() != rb || done_cnt - db != 1) begin
            fails++; $display("FAIL r1_timeout: err=%0d rx=%0d done=%0d want 1/0/1", err, rx_q.size() - rb, done_cnt - db);
        end
        asserts++;
        if (mosi_q.size() - mb != 6 + NCR) begin
            fails++; $display("FAIL r1_timeout_polls: got %0d want %0d", mosi_q.size() - mb, 6 + NCR);
        end
    endtask

    task automatic test_r1_error;
        miso_mem.delete(); push_ff(6); miso_mem.push_back(8'h04);
        run_txn(6'd17, 32'd1, 1'b0, 1'b1, 0);
        asserts++;
        if (err !== 2'd3 || r1 !== 8'h04 || mosi_q.size() - mb != 7 || rx_q.size() != rb) begin
            fails++; $display("FAIL r1_error: err=%0d r1=%h bytes=%0d want 3/04/7", err, r1, mosi_q.size() - mb);
        end
    endtask

    task automatic test_bad_token_busy_start;
        logic [7:0] exp_f[5];
        exp_f = '{8'h51, 8'h00, 8'h00, 8'h00, 8'h05};
        miso_mem.delete(); push_ff(6);
        miso_mem.push_back(8'h00); miso_mem.push_back(8'hFF); miso_mem.push_back(8'h05);
        run_txn(6'd17, 32'd5, 1'b0, 1'b1, 100);
        for (int i = 0; i < 5; i++) begin
            asserts++;
            if (mosi_q[mb + i] !== exp_f[i]) begin
                fails++; $display("FAIL busy_start_frame[%0d]: got %h want %h", i, mosi_q[mb + i], exp_f[i]);
            end
        end
        asserts++;
        if (err !== 2'd3 || rx_q.size() != rb || done_cnt - db != 1) begin
            fails++; $display("FAIL bad_token: err=%0d rx=%0d done=%0d want 3/0/1", err, rx_q.size() - rb, done_cnt - db);
        end
        asserts++;
        if (mosi_q.size() - mb != 9 || busy !== 1'b0) begin
            fails++; $display("FAIL bad_token_bytes: got %0d busy=%b want 9/0", mosi_q.size() - mb, busy);
        end
    endtask

    task automatic test_tok_timeout;
        miso_mem.delete(); push_ff(6); miso_mem.push_back(8'h00);
        run_txn(6'd17, 32'd2, 1'b0, 1'b1, 0);
        asserts++;
        if (err !== 2'd2 || mosi_q.size() - mb != 7 + TOKM || rx_q.size() != rb) begin
            fails++; $display("FAIL tok_timeout: err=%0d bytes=%0d want 2/%0d", err, mosi_q.size() - mb, 7 + TOKM);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        load_read_stream();
        rb = rx_q.size(); db = done_cnt;
        @(negedge clk);
        cmdIDX = 6'd17; cmdARG = 32'd5; rspLONG = 1'b0; rdDATA = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (rx_q.size() - rb < 100 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        asserts++;
        if (rx_q.size() - rb < 100) begin
            fails++; $display("FAIL reset_mid_wait: got %0d bytes want 100", rx_q.size() - rb);
        end
        reset = 1'b0;
        #1;
        asserts++;
        if ({sdCS, busy, rxVALID, sdSCLK} !== 4'b1000) begin
            fails++; $display("FAIL reset_mid_outputs: got %b want 1000", {sdCS, busy, rxVALID, sdSCLK});
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        asserts++;
        if (done_cnt != db || rx_q.size() - rb > 101) begin
            fails++; $display("FAIL reset_mid_abort: done=%0d rx=%0d want 0/<=101", done_cnt - db, rx_q.size() - rb);
        end
        miso_mem.delete(); push_ff(6); miso_mem.push_back(8'h01);
        run_txn(6'd0, 32'h0, 1'b0, 1'b0, 0);
        asserts++;
        if (mosi_q[mb] !== 8'h40 || mosi_q[mb + 5] !== 8'h95 || r1 !== 8'h01 || err !== 2'd0) begin
            fails++; $display("FAIL reset_mid_cmd0: frame %h..%h r1=%h err=%0d want 40..95/01/0", mosi_q[mb], mosi_q[mb + 5], r1, err);
        end
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        test_cmd0();
        test_cmd8();
        test_read();
        test_r1_timeout();
        test_r1_error();
        test_bad_token_busy_start();
        test_tok_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule

// File: doc/sd_spi_cmd.md
# sd_spi_cmd

SPI-mode SD command initiator for the RK8E disk path: frames a single SD command (CMD byte, 32-bit argument, CRC7), clocks it out over SPI and collects the R1 response. It also collects the optional 4-byte R3/R7 tail and, on request, a 512-byte read data block. Read data bytes are streamed to the sector-buffer logic one at a time. It is the host-side counterpart of the SD card model used in the SD testbenches and sits between the RK8E controller sequencer and the SD socket pins.

## Interface
- CLKDIV, 4: clk cycles per SCLK half-period; legal range 4..255. The minimum of 4 covers card-side MISO latency.
- NCR_MAX, 8: maximum 0xFF polling bytes before R1.
- TOK_MAX, 1024: maximum polling bytes before the data token.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; accepted only when busy=0
- cmdIDX  in  6  command index; sampled on accepted start
- cmdARG  in  32  command argument; sampled on accepted start
- rspLONG  in  1  1 = read 4 extra response bytes (R3/R7)
- rdDATA  in  1  1 = read data token, 512 data bytes and 2 CRC bytes after R1
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at end of transaction
- err  out  2  0 ok, 1 R1 timeout, 2 token timeout, 3 error token or R1 error
- r1  out  8  last R1 byte
- rspEXT  out  32  last R3/R7 tail, MSB first
- rxDATA  out  8  read data byte
- rxVALID  out  1  one-cycle strobe per data byte
- sdMISO  in  1  card data out
- sdMOSI  out  1  card data in
- sdSCLK  out  1  SPI clock (mode 0, idle low)
- sdCS  out  1  chip select, active low

## Operation
- Reset values: sdCS=1, sdSCLK=0, sdMOSI=1, busy=0, done=0, err=0, r1=8'hFF, rspEXT=0, rxDATA=0, rxVALID=0; state IDLE.
- The byte engine shifts MSB first. The same engine is used for every byte; it transmits 8'hFF in every state except CMD.
- Command frame: {2'b01, cmdIDX}, cmdARG[31:24..7:0], {crc7, 1'b1}.
  - crc7 uses polynomial x^7+x^3+1 over the first 40 bits, initial value 0.
  - CMD0 with arg 0 therefore yields 0x95; CMD8 with arg 0x1AA yields 0x87.
- States:
  - IDLE: on start, latch inputs, set busy=1 and sdCS=0, go to CMD.
  - CMD: send the 6 frame bytes, then go to R1.
  - R1: send FF bytes until a received byte has bit7=0; latch it into r1.
    - If NCR_MAX bytes pass without one: err=1, go to FIN.
    - Otherwise go to EXT if rspLONG=1, else TOK if rdDATA=1, else FIN.
  - EXT: receive 4 bytes into rspEXT, then go to TOK if rdDATA=1, else FIN.
  - TOK: entered only if r1[7:1]==0; otherwise err=3 and go to FIN.
    - Poll until a byte != 8'hFF arrives.
    - 8'hFE goes to DATA; any other value sets err=3 and goes to FIN.
    - TOK_MAX bytes without a non-FF byte: err=2, go to FIN.
  - DATA: 512 bytes, each presented on rxDATA with one rxVALID pulse; a 9-bit counter wraps 511→0 on exit to CRC.
  - CRC: receive 2 bytes and discard them.
  - FIN: sdCS=1, clock one more FF byte with CS high, then pulse done, clear busy, return to IDLE.
- err is cleared on accepted start and holds until the next start.
- start while busy=1 is ignored; no queuing.
- reset asserted mid-transaction forces all outputs to their reset values immediately. No done pulse is issued, and any partial block is abandoned.

## Timing
- Start accepted at edge N: at N+1, sdCS=0, sdMOSI=bit7, busy=1.
- Each bit: SCLK low for CLKDIV cycles, then high for CLKDIV cycles. One byte takes 16*CLKDIV cycles.
- sdMOSI changes only on the cycle SCLK falls, and on the CS-assert cycle for the first bit.
- sdMISO is sampled on the last clk of each SCLK high phase.
- rxVALID pulses on the cycle after the 8th bit of a data byte is sampled. rxDATA holds that byte until the next strobe.
- done pulses one cycle after the trailing CS-high byte's last SCLK falling edge. busy=0 on the same cycle.
- Minimum transaction (R1 on first poll, no extras): 8 bytes plus 2 cycles.

## Test plan
- CMD0 with arg 0 against the SD card model: MOSI bytes 40 00 00 00 00 95 → r1=8'h01, err=0, one done pulse, sdCS back to 1.
- CMD8 with arg 32'h1AA, rspLONG=1 → frame ends 0x87, r1=8'h01, rspEXT=32'h000001AA.
- CMD17 with arg 5, rdDATA=1, model image loaded → exactly 512 rxVALID pulses; bytes equal image[2560..3071]; err=0.
- MISO held 1: R1 timeout → err=1 after 8 poll bytes, no rxVALID, done pulses.
- Model returns token 8'h05 instead of 8'hFE → err=3, zero rxVALID. Separately, start pulsed while busy → ignored, frame unchanged.
- reset asserted after 100 data bytes → sdCS=1, busy=0, rxVALID=0 at once. A subsequent CMD0 completes normally.
